// File: rtl/uart_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : uart_reg_bridge
// Description : Command responder on the parallel side of a UART. Decodes
//               binary host commands that write or read a small byte register
//               file and answers each command with exactly one reply byte.
//               The transmitter has no busy output, so replies are spaced by
//               a fixed gap counted here.
//
//               Commands : 'W' addr data -> reply 'K'
//                          'R' addr      -> reply register byte
//                          anything else, or addr out of range -> reply '?'
//
// Ports       : clk      - system clock, all logic on posedge
//               rst      - synchronous active-high reset
//               rx_valid - one-cycle strobe, rx_data holds a new byte
//               rx_data  - received byte
//               tx_send  - one-cycle strobe to the UART transmitter
//               tx_data  - reply byte, stable from tx_send to end of gap
//               wr_stb   - one-cycle pulse after a register write
//               wr_addr  - address of the last write
//               reg_q    - flat register file, reg k at [8k+7:8k]
//               busy     - high whenever the responder is not idle
//               overrun  - sticky, a byte arrived while a reply was pending
//
// Revision    : 1.0 - initial release
// ============================================================================
module uart_reg_bridge #(
    parameter int CLOCK_FREQ_HZ  = 12000000,
    parameter int BAUD_RATE      = 9600,
    parameter int REG_COUNT      = 16,
    parameter int ADDR_WIDTH     = 4,
    parameter int GAP_CYCLES     = 11 * CLOCK_FREQ_HZ / BAUD_RATE,
    parameter int TIMEOUT_CYCLES = 12500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic                    tx_send,
    output logic [7:0]              tx_data,
    output logic                    wr_stb,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [8*REG_COUNT-1:0]  reg_q,
    output logic                    busy,
    output logic                    overrun
);

    // One shared timer serves both the inter-byte timeout and the reply gap;
    // the extra bit keeps the terminal count well clear of wrap-around.
    localparam int c_TIMER_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int c_TIMER_W   = $clog2(c_TIMER_MAX) + 1;

    localparam logic [c_TIMER_W-1:0] c_GAP_LAST     = c_TIMER_W'(GAP_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_TIMEOUT_LAST = c_TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_ONE    = c_TIMER_W'(1);

    // Nine bits so REG_COUNT=256 still compares correctly against an 8-bit address.
    localparam logic [8:0] c_REG_LIMIT = 9'(REG_COUNT);

    localparam logic [7:0] c_CMD_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] c_CMD_READ  = 8'h52;  // 'R'
    localparam logic [7:0] c_RSP_OK    = 8'h4B;  // 'K'
    localparam logic [7:0] c_RSP_ERR   = 8'h3F;  // '?'
    localparam logic [7:0] c_TX_IDLE   = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CMD_ADDR = 3'd1,
        S_CMD_DATA = 3'd2,
        S_SEND     = 3'd3,
        S_GAP      = 3'd4
    } state_t;

    state_t                  r_state;
    logic [c_TIMER_W-1:0]    r_timer;
    logic                    r_is_write;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_addr_ok;
    logic [7:0]              r_tx_data;
    logic                    r_tx_send;
    logic                    r_wr_stb;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic                    r_overrun;
    logic [7:0]              r_regs [REG_COUNT];

    state_t                  w_state_next;
    logic [c_TIMER_W-1:0]    w_timer_next;
    logic                    w_is_write_next;
    logic [ADDR_WIDTH-1:0]   w_addr_next;
    logic                    w_addr_ok_next;
    logic [7:0]              w_tx_data_next;
    logic                    w_tx_send_next;
    logic                    w_wr_stb_next;
    logic [ADDR_WIDTH-1:0]   w_wr_addr_next;
    logic                    w_overrun_next;
    logic                    w_reg_we;
    logic                    w_rx_addr_ok;
    logic [7:0]              w_rd_data;

    assign w_rx_addr_ok = ({1'b0, rx_data} < c_REG_LIMIT);

    // The read path looks straight into the register array, so a write that
    // completed on an earlier command is always what a later read returns.
    // Out-of-range indices are never used because w_rx_addr_ok gates the reply.
    assign w_rd_data = r_regs[rx_data[ADDR_WIDTH-1:0]];

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_addr_ok  <= 1'b0;
            r_tx_data  <= c_TX_IDLE;
            r_tx_send  <= 1'b0;
            r_wr_stb   <= 1'b0;
            r_wr_addr  <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_timer    <= w_timer_next;
            r_is_write <= w_is_write_next;
            r_addr     <= w_addr_next;
            r_addr_ok  <= w_addr_ok_next;
            r_tx_data  <= w_tx_data_next;
            r_tx_send  <= w_tx_send_next;
            r_wr_stb   <= w_wr_stb_next;
            r_wr_addr  <= w_wr_addr_next;
            r_overrun  <= w_overrun_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_timer_next    = r_timer;
        w_is_write_next = r_is_write;
        w_addr_next     = r_addr;
        w_addr_ok_next  = r_addr_ok;
        w_tx_data_next  = r_tx_data;
        w_tx_send_next  = 1'b0;
        w_wr_stb_next   = 1'b0;
        w_wr_addr_next  = r_wr_addr;
        w_overrun_next  = r_overrun;
        w_reg_we        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (rx_valid) begin
                    w_timer_next = '0;
                    if (rx_data == c_CMD_WRITE || rx_data == c_CMD_READ) begin
                        w_is_write_next = (rx_data == c_CMD_WRITE);
                        w_state_next    = S_CMD_ADDR;
                    end else begin
                        w_tx_data_next = c_RSP_ERR;
                        w_state_next   = S_SEND;
                    end
                end
            end

            S_CMD_ADDR: begin
                if (rx_valid) begin
                    w_timer_next   = '0;
                    w_addr_next    = rx_data[ADDR_WIDTH-1:0];
                    w_addr_ok_next = w_rx_addr_ok;
                    if (r_is_write) begin
                        w_state_next = S_CMD_DATA;
                    end else begin
                        w_tx_data_next = w_rx_addr_ok ? w_rd_data : c_RSP_ERR;
                        w_state_next   = S_SEND;
                    end
                end else if (r_timer == c_TIMEOUT_LAST) begin
                    w_timer_next = '0;
                    w_state_next = S_IDLE;
                end else begin
                    w_timer_next = r_timer + c_TIMER_ONE;
                end
            end

            S_CMD_DATA: begin
                if (rx_valid) begin
                    // The data byte is consumed even for an illegal address,
                    // so the host stream stays aligned to command boundaries.
                    if (r_addr_ok) begin
                        w_reg_we       = 1'b1;
                        w_wr_stb_next  = 1'b1;
                        w_wr_addr_next = r_addr;
                        w_tx_data_next = c_RSP_OK;
                    end else begin
                        w_tx_data_next = c_RSP_ERR;
                    end
                    w_timer_next = '0;
                    w_state_next = S_SEND;
                end else if (r_timer == c_TIMEOUT_LAST) begin
                    w_timer_next = '0;
                    w_state_next = S_IDLE;
                end else begin
                    w_timer_next = r_timer + c_TIMER_ONE;
                end
            end

            S_SEND: begin
                // tx_send is registered, so the strobe appears in the first
                // GAP cycle; the gap count therefore starts at that cycle.
                w_tx_send_next = 1'b1;
                w_timer_next   = '0;
                w_state_next   = S_GAP;
                if (rx_valid) begin
                    w_overrun_next = 1'b1;
                end
            end

            S_GAP: begin
                if (rx_valid) begin
                    w_overrun_next = 1'b1;
                end
                if (r_timer == c_GAP_LAST) begin
                    w_timer_next = '0;
                    w_state_next = S_IDLE;
                end else begin
                    w_timer_next = r_timer + c_TIMER_ONE;
                end
            end

            default: begin
                w_timer_next = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else if (w_reg_we) begin
            r_regs[r_addr] <= rx_data;
        end
    end

    generate
        for (genvar k = 0; k < REG_COUNT; k++) begin : g_flat
            assign reg_q[8*k +: 8] = r_regs[k];
        end
    endgenerate

    assign tx_send = r_tx_send;
    assign tx_data = r_tx_data;
    assign wr_stb  = r_wr_stb;
    assign wr_addr = r_wr_addr;
    assign busy    = (r_state != S_IDLE);
    assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_reg_bridge
// Description : Self-checking bench for uart_reg_bridge. Directed protocol
//               cases followed by random command streams, all checked against
//               a byte-array model of the register file and the reply rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_reg_bridge;

    localparam int REG_COUNT  = 16;
    localparam int ADDR_WIDTH = 4;
    localparam int GAP        = 40;
    localparam int TIMEOUT    = 60;

    localparam logic [7:0] c_W   = 8'h57;
    localparam logic [7:0] c_R   = 8'h52;
    localparam logic [7:0] c_K   = 8'h4B;
    localparam logic [7:0] c_ERR = 8'h3F;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   rx_valid;
    logic [7:0]             rx_data;
    logic                   tx_send;
    logic [7:0]             tx_data;
    logic                   wr_stb;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [8*REG_COUNT-1:0] reg_q;
    logic                   busy;
    logic                   overrun;

    always #5 clk = ~clk;

    uart_reg_bridge #(
        .CLOCK_FREQ_HZ (12000000),
        .BAUD_RATE     (9600),
        .REG_COUNT     (REG_COUNT),
        .ADDR_WIDTH    (ADDR_WIDTH),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .tx_send (tx_send),
        .tx_data (tx_data),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr),
        .reg_q   (reg_q),
        .busy    (busy),
        .overrun (overrun)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] m_regs [REG_COUNT];
    logic       exp_overrun;
    int         prev_tx;
    int         last_strobe;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8*REG_COUNT-1:0] model_flat();
        logic [8*REG_COUNT-1:0] v;
        for (int i = 0; i < REG_COUNT; i++) v[8*i +: 8] = m_regs[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < REG_COUNT; i++) m_regs[i] = 8'h00;
        exp_overrun = 1'b0;
        prev_tx     = -1;
    endtask

    // Drivers assume they are called just after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid    = 1'b1;
        rx_data     = b;
        last_strobe = cyc;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic check_reset_state(input string pfx);
        check_val({pfx, "_tx_send"}, tx_send, 1'b0);
        check_val({pfx, "_tx_data"}, tx_data, 8'hFF);
        check_val({pfx, "_wr_stb"},  wr_stb,  1'b0);
        check_val({pfx, "_wr_addr"}, wr_addr, '0);
        check_val({pfx, "_reg_q"},   reg_q,   '0);
        check_val({pfx, "_busy"},    busy,    1'b0);
        check_val({pfx, "_overrun"}, overrun, 1'b0);
    endtask

    // Send one full command, then watch the reply, write strobe and gap.
    task automatic run_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input int max_gap);
        int         nb;
        int         ai;
        logic [7:0] exp_reply;
        logic       exp_wr;
        int         n_tx, n_wr, t_tx, t_wr, t_idle;
        logic [7:0] tx_seen, q_at_wr;
        logic [ADDR_WIDTH-1:0] wa;
        logic       stable;

        ai     = int'(b1);
        exp_wr = 1'b0;
        if (b0 == c_W) begin
            nb = 3;
            if (ai < REG_COUNT) begin
                exp_reply = c_K;
                exp_wr    = 1'b1;
            end else begin
                exp_reply = c_ERR;
            end
        end else if (b0 == c_R) begin
            nb        = 2;
            exp_reply = (ai < REG_COUNT) ? m_regs[ai] : c_ERR;
        end else begin
            nb        = 1;
            exp_reply = c_ERR;
        end

        for (int i = 0; i < nb; i++) begin
            if (i > 0) idle($urandom_range(max_gap, 0));
            send_byte(i == 0 ? b0 : (i == 1 ? b1 : b2));
        end

        n_tx = 0; n_wr = 0; t_tx = 0; t_wr = 0; t_idle = -1;
        tx_seen = 8'h00; q_at_wr = 8'h00; wa = '0; stable = 1'b1;
        for (int k = 0; k < GAP + 20; k++) begin
            @(negedge clk);
            if (tx_send) begin
                n_tx++;
                t_tx    = cyc;
                tx_seen = tx_data;
            end else if (n_tx > 0 && busy && tx_data !== tx_seen) begin
                stable = 1'b0;
            end
            if (wr_stb) begin
                n_wr++;
                t_wr    = cyc;
                wa      = wr_addr;
                q_at_wr = reg_q[8*(ai % REG_COUNT) +: 8];
            end
            if (n_tx > 0 && !busy) begin
                t_idle = cyc;
                break;
            end
        end

        if (exp_wr) m_regs[ai] = b2;

        check_val("tx_count",   n_tx, 1);
        check_val("tx_data",    tx_seen, exp_reply);
        check_val("tx_latency", t_tx - last_strobe, 2);
        check_val("tx_hold",    stable, 1'b1);
        check_val("wr_count",   n_wr, exp_wr ? 1 : 0);
        if (exp_wr) begin
            check_val("wr_addr",    wa, b1[ADDR_WIDTH-1:0]);
            check_val("wr_data",    q_at_wr, b2);
            check_val("wr_latency", t_wr - last_strobe, 1);
        end
        check_val("gap_done",   (t_idle >= 0) && (t_idle - t_tx >= GAP), 1'b1);
        if (prev_tx >= 0) check_val("tx_spacing", (t_tx - prev_tx) >= GAP, 1'b1);
        prev_tx = t_tx;
        check_val("reg_file",   reg_q, model_flat());
        check_val("overrun",    overrun, exp_overrun);

        @(posedge clk);
        #1;
    endtask

    task automatic timeout_test(input logic [7:0] addr);
        int n_tx = 0;
        int n_wr = 0;
        send_byte(c_W);
        idle(2);
        send_byte(addr);
        @(negedge clk);
        check_val("to_busy_mid", busy, 1'b1);
        for (int k = 0; k < TIMEOUT + 3; k++) begin
            @(negedge clk);
            if (tx_send) n_tx++;
            if (wr_stb) n_wr++;
        end
        check_val("to_busy_end", busy, 1'b0);
        check_val("to_no_tx",    n_tx, 0);
        check_val("to_no_wr",    n_wr, 0);
        check_val("to_reg_file", reg_q, model_flat());
        @(posedge clk);
        #1;
    endtask

    task automatic overrun_test();
        int n_tx = 0;
        check_val("ovr_before", overrun, 1'b0);
        send_byte(c_R);
        send_byte(8'h03);
        idle(8);
        send_byte(c_R);
        exp_overrun = 1'b1;
        @(negedge clk);
        check_val("ovr_set", overrun, 1'b1);
        for (int k = 0; k < GAP + TIMEOUT + 10; k++) begin
            @(negedge clk);
            if (tx_send) n_tx++;
        end
        check_val("ovr_no_extra_tx", n_tx, 0);
        check_val("ovr_idle",        busy, 1'b0);
        check_val("ovr_sticky",      overrun, 1'b1);
        prev_tx = -1;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_in_data_test();
        int n_tx = 0;
        int n_wr = 0;
        send_byte(c_W);
        idle(1);
        send_byte(8'h05);
        idle(2);
        check_val("rd_busy_pre", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        check_reset_state("rst_data");
        for (int k = 0; k < TIMEOUT + GAP + 5; k++) begin
            @(negedge clk);
            if (tx_send) n_tx++;
            if (wr_stb) n_wr++;
        end
        check_val("rst_data_no_tx", n_tx, 0);
        check_val("rst_data_no_wr", n_wr, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_in_gap_test();
        int n_tx = 0;
        bit seen = 1'b0;
        send_byte(c_R);
        send_byte(8'h07);
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (tx_send) seen = 1'b1;
        end
        check_val("rg_reply_seen", seen, 1'b1);
        @(posedge clk);
        #1;
        idle(3);
        check_val("rg_busy_pre", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        check_reset_state("rst_gap");
        for (int k = 0; k < GAP + 10; k++) begin
            @(negedge clk);
            if (tx_send) n_tx++;
        end
        check_val("rst_gap_no_tx", n_tx, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] b0, b1, b2;
        int         sel;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("por");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Directed protocol cases
        run_cmd(c_W, 8'h03, 8'hA5, 2);
        run_cmd(c_R, 8'h03, 8'h00, 2);
        run_cmd(8'h41, 8'h00, 8'h00, 0);
        run_cmd(c_R, 8'h20, 8'h00, 1);
        run_cmd(c_W, 8'h10, 8'h55, 1);
        run_cmd(c_W, 8'h0F, 8'h9C, 0);
        run_cmd(c_R, 8'h0F, 8'h00, 0);
        timeout_test(8'h02);
        run_cmd(c_R, 8'h02, 8'h00, 0);
        run_cmd(c_R, 8'h03, 8'h00, 0);
        run_cmd(c_R, 8'h03, 8'h00, 0);
        overrun_test();
        run_cmd(c_R, 8'h03, 8'h00, 0);
        run_cmd(c_W, 8'h07, 8'h3C, 1);
        reset_in_data_test();
        run_cmd(c_W, 8'h07, 8'h3C, 1);
        reset_in_gap_test();

        // Random command streams
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(9, 0);
            if (sel < 4) begin
                b0 = c_W;
            end else if (sel < 8) begin
                b0 = c_R;
            end else begin
                b0 = 8'($urandom);
                if (b0 == c_W || b0 == c_R) b0 = 8'h00;
            end
            b1 = ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'($urandom_range(REG_COUNT - 1, 0));
            b2 = 8'($urandom);
            run_cmd(b0, b1, b2, 3);
            idle($urandom_range(3, 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
